frame_stim_driver: RTL

// - Transmit end of the frame protocol consumed by the output monitor. Replays a preloaded vector

---
 rtl/frame_stim_pkg.sv | 29 ++
 rtl/frame_vec_ram.sv | 36 +++
 rtl/frame_stim_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/frame_stim_pkg.sv
// Shared types and width constants for the frame stimulus driver.
//   beat_t   : one beat, DATA_ELEMENTS words packed with element 0 in the LSBs
//   state_t  : driver FSM states
//   clamp_len: limits a requested frame length to the buffer depth
package frame_stim_pkg;

  localparam int unsigned DATA_WIDTH    = 33;
  localparam int unsigned DATA_ELEMENTS = 2;
  localparam int unsigned BEAT_W        = DATA_WIDTH * DATA_ELEMENTS;
  localparam int unsigned DEPTH         = 256;
  localparam int unsigned ADDR_W        = $clog2(DEPTH);
  localparam int unsigned LEN_W         = $clog2(DEPTH) + 1;
  localparam int unsigned GAP_W         = 8;

  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    SEND,
    GAP,
    DONE
  } state_t;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  endfunction

endpackage

// File: rtl/frame_vec_ram.sv
// Vector buffer: DEPTH x beat_t, one write port and one synchronous read port.
// Ports:
//   clk, rst        clock; rst clears only the read register, never the storage
//   we/wr_addr/wr_data   write port
//   re/rd_addr     read request; rd_data updates on the following edge
//   rd_data        registered read data, held while re is low
module frame_vec_ram
  import frame_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [BEAT_W-1:0] rd_data
);

  beat_t mem [DEPTH];

  // Storage has no reset so the loaded vectors survive a driver reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read register holds its value between requests; this is what keeps a stalled beat stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (re) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/frame_stim_driver.sv
// Replays the vector buffer into the UUT as one frame: start_frame strobe, then
// frame_len valid/ready beats with an optional idle gap after each accepted beat.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data         buffer load port (honoured only while idle)
//   start/frame_len/gap           frame request, sampled in IDLE
//   ready                         UUT accepts the current beat
//   start_frame/valid/data_out    frame output
//   beat_cnt                      beats accepted in the current/last frame
//   busy/done/err                 status; err is sticky until the next accepted start
module frame_stim_driver
  import frame_stim_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [BEAT_W-1:0] wr_data,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [GAP_W-1:0]  gap,
  input  logic              ready,
  output logic              start_frame,
  output logic              valid,
  output logic [BEAT_W-1:0] data_out,
  output logic [LEN_W-1:0]  beat_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            state, state_next;
  logic [LEN_W-1:0]  len_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [LEN_W-1:0]  beat_inc;
  logic              accept;
  logic              last;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              ram_we;
  logic              start_ok;

  assign beat_inc = beat_cnt + LEN_W'(1);
  assign accept   = (state == SEND) && ready;
  assign last     = accept && (beat_inc == len_q);
  assign ram_we   = wr_en && (state == IDLE);
  assign start_ok = start && (state == IDLE);

  frame_vec_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (ram_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .re      (rd_en),
    .rd_addr (rd_addr),
    .rd_data (data_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and buffer read requests.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    rd_addr    = '0;
    case (state)
      IDLE: if (start) state_next = SOF;
      SOF: begin
        rd_en      = 1'b1;
        state_next = (len_q == '0) ? DONE : SEND;
      end
      SEND: begin
        if (last) begin
          state_next = DONE;
        end else if (accept) begin
          // Prefetch the next beat so it is ready on the next cycle.
          rd_en      = 1'b1;
          rd_addr    = ADDR_W'(beat_inc);
          state_next = (gap_q != '0) ? GAP : SEND;
        end
      end
      GAP:     if (gap_cnt_q <= GAP_W'(1)) state_next = SEND;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered outputs follow the next state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_frame <= 1'b0;
      valid       <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_frame <= (state_next == SOF);
      valid       <= (state_next == SEND);
      done        <= (state_next == DONE);
      busy        <= (state_next != IDLE);
    end
  end

  // Frame parameters, beat/gap counters and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      beat_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q    <= clamp_len(frame_len);
        gap_q    <= gap;
        beat_cnt <= '0;
        err      <= (frame_len > LEN_W'(DEPTH));
      end else begin
        if (accept) beat_cnt <= beat_inc;
        if ((state != IDLE) && (start || wr_en)) err <= 1'b1;
      end
      if (accept && !last) gap_cnt_q <= gap_q;
      else if (state == GAP) gap_cnt_q <= gap_cnt_q - GAP_W'(1);
    end
  end

endmodule
